exe_stage: RTL
==============

# exe_stage

Execute stage of the ARM-subset pipeline. Takes val1 (Rn) and the already-shifted/rotated/immediate val2 from the val2 generator, performs the ALU operation selected by the decoded 4-bit execute command, and maintains the NZCV status register. Latches the result and the forwarded memory/write-back controls into the EX/MEM pipeline register. Supports stall (freeze) and bubble insertion (flush).

## Interface
Parameters:
- WIDTH, 32, datapath width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hold the EX/MEM register and status register.
- flush  in  1  turn the current instruction into a bubble.
- in_valid  in  1  the ID/EX slot holds a real instruction.
- exe_cmd  in  4  ALU operation code.
- s_bit  in  1  update NZCV.
- val1  in  WIDTH  Rn value.
- val2  in  WIDTH  output of the val2 generator.
- mem_r_en, mem_w_en, wb_en  in  1 each  controls passed through.
- dest  in  4  destination register.
- st_val  in  WIDTH  Rd value for STR.
- out_valid  out  1  EX/MEM slot valid.
- alu_result  out  WIDTH  registered result/address.
- out_mem_r_en, out_mem_w_en, out_wb_en  out  1 each  registered controls.
- out_dest  out  4  registered destination register.
- out_st_val  out  WIDTH  registered store data.
- status  out  4  NZCV register, {N,Z,C,V}; feeds the ID condition check.

## Operation
- exe_cmd encoding:
  - MOV=0001, result = val2.
  - MVN=1001, result = ~val2.
  - ADD=0010; LDR, STR and address generation also use ADD.
  - ADC=0011, result = val1+val2+C.
  - SUB=0100; CMP also uses SUB.
  - SBC=0101, result = val1−val2−!C.
  - AND=0110; TST also uses AND.
  - ORR=0111.
  - EOR=1000.
  - Any other code: result 0, flags are not written.
- C is the carry-in from the *registered* status.
- Flags:
  - N = r[31]; Z = (r==0) for all valid ops.
  - Add family: C = bit 32 of the 33-bit sum. V = (a[31]==b[31]) && (r[31]!=a[31]).
  - Subtract family: C = NOT borrow, i.e. 1 when no borrow occurs (ARM convention). V = (a[31]!=b[31]) && (r[31]!=a[31]).
  - Logical/move ops: C and V are kept unchanged.
- The status register is written on the edge only when all of these hold: in_valid, s_bit, !freeze, !flush, and the code is a valid op.
- Priority on each edge: rst > flush > freeze > normal load.
- Flush:
  - out_valid=0 and all out_* controls = 0; data outputs are don't-care but driven 0.
  - status is not written.
- Freeze: all outputs and status hold their previous values.
- A cycle with in_valid=0 loads a bubble (same as flush) and writes no flags.
- CMP/TST arrive with wb_en=0 and are passed through as given; this block never alters controls except on a bubble.

## Timing
- Latency is one cycle: inputs sampled at edge k appear on outputs after edge k.
- status is visible in the cycle after the edge where the flag-setting instruction is latched. ADC/SBC/conditional instructions issued directly behind it see the new flags.
- Reset value of every output is 0, including status=0000 and out_valid=0.
- Reset during freeze or flush still clears everything.
- Back-to-back ADC chain: each instruction uses the C written by its predecessor.
- Freeze held N cycles, then released: the instruction present at release loads exactly once.

## Structure
- Shared package `arm_pkg`:
  - EXE_CMD localparams (MOV…EOR).
  - Flag index constants N=3, Z=2, C=1, V=0.
- Sub-module `alu`: purely combinational. Inputs: val1, val2, exe_cmd, c_in. Outputs: result, nzcv_next, flag_we.
- `exe_stage` holds the status register and the EX/MEM register.

## Test plan
- Reset: assert rst for 2 cycles with random inputs → all outputs 0, status=0000.
- Add overflow: ADD s=1, val1=0x7FFFFFFF, val2=1 → alu_result=0x80000000, status=1001.
- CMP then conditional carry:
  - SUB s=1, val1=5, val2=5 → result 0, status=0110.
  - Next cycle ADC val1=1, val2=1 → result 3.
- Borrow and logical op:
  - SUB s=1, 0−1 → 0xFFFFFFFF, status=1000.
  - Then AND s=1, 0xF0 & 0x0F → 0, status=0100 (C and V kept from previous).
- Freeze/flush:
  - MOV val2=0xAB with freeze=1 for 3 cycles → outputs unchanged.
  - Release → alu_result=0xAB.
  - Then flush with SUB s=1 present → out_valid=0, wb_en=0, status unchanged.
- STR passthrough: exe_cmd=ADD, val1=0x400, val2=8, mem_w_en=1, st_val=0xDEAD → alu_result=0x408, out_mem_w_en=1, out_st_val=0xDEAD, status unchanged (s_bit=0).

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM-subset pipeline: execute command codes and NZCV bit positions.
package arm_pkg;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Per-flag write masks: arithmetic ops write all four, logical/move ops only N and Z.
  localparam logic [3:0] WE_ARITH = 4'b1111;
  localparam logic [3:0] WE_LOGIC = 4'b1100;
  localparam logic [3:0] WE_NONE  = 4'b0000;

endpackage

// File: rtl/alu.sv
// Combinational ALU: result, candidate NZCV and a per-flag write mask for the execute command.
module alu
  import arm_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [3:0]       exe_cmd,
  input  logic             c_in,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nzcv_next,
  output logic [3:0]       flag_we
);

  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_v;

  // Subtraction is a + ~b + cin, so the carry out is directly the ARM "no borrow" C.
  always_comb begin
    w_b   = val2;
    w_cin = 1'b0;
    case (exe_cmd)
      EXE_ADC: w_cin = c_in;
      EXE_SUB: begin
        w_b   = ~val2;
        w_cin = 1'b1;
      end
      EXE_SBC: begin
        w_b   = ~val2;
        w_cin = c_in;
      end
      default: ;
    endcase
  end

  assign w_sum = {1'b0, val1} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};

  // With b already inverted for subtraction, one overflow rule covers both families.
  assign w_v = (val1[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != val1[WIDTH-1]);

  always_comb begin
    result  = '0;
    flag_we = WE_NONE;
    case (exe_cmd)
      EXE_MOV: begin
        result  = val2;
        flag_we = WE_LOGIC;
      end
      EXE_MVN: begin
        result  = ~val2;
        flag_we = WE_LOGIC;
      end
      EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: begin
        result  = w_sum[WIDTH-1:0];
        flag_we = WE_ARITH;
      end
      EXE_AND: begin
        result  = val1 & val2;
        flag_we = WE_LOGIC;
      end
      EXE_ORR: begin
        result  = val1 | val2;
        flag_we = WE_LOGIC;
      end
      EXE_EOR: begin
        result  = val1 ^ val2;
        flag_we = WE_LOGIC;
      end
      default: ;
    endcase
  end

  always_comb begin
    nzcv_next         = '0;
    nzcv_next[FLAG_N] = result[WIDTH-1];
    nzcv_next[FLAG_Z] = (result == '0);
    nzcv_next[FLAG_C] = w_sum[WIDTH];
    nzcv_next[FLAG_V] = w_v;
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, NZCV status register and the EX/MEM pipeline register with freeze/flush.
module exe_stage
  import arm_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [3:0]       exe_cmd,
  input  logic             s_bit,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             wb_en,
  input  logic [3:0]       dest,
  input  logic [WIDTH-1:0] st_val,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic             out_mem_r_en,
  output logic             out_mem_w_en,
  output logic             out_wb_en,
  output logic [3:0]       out_dest,
  output logic [WIDTH-1:0] out_st_val,
  output logic [3:0]       status
);

  logic [WIDTH-1:0] w_result;
  logic [3:0]       w_nzcv;
  logic [3:0]       w_flag_we;
  logic [3:0]       w_mask;

  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_mem_r_en;
  logic             r_mem_w_en;
  logic             r_wb_en;
  logic [3:0]       r_dest;
  logic [WIDTH-1:0] r_st_val;
  logic [3:0]       r_status;

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .val1     (val1),
    .val2     (val2),
    .exe_cmd  (exe_cmd),
    .c_in     (r_status[FLAG_C]),
    .result   (w_result),
    .nzcv_next(w_nzcv),
    .flag_we  (w_flag_we)
  );

  assign w_mask = s_bit ? w_flag_we : WE_NONE;

  // Priority: reset, then flush, then freeze; an empty ID/EX slot loads a bubble.
  always_ff @(posedge clk) begin
    if (rst || flush || (!freeze && !in_valid)) begin
      r_valid    <= 1'b0;
      r_result   <= '0;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_wb_en    <= 1'b0;
      r_dest     <= '0;
      r_st_val   <= '0;
      if (rst) r_status <= '0;
    end else if (!freeze) begin
      r_valid    <= 1'b1;
      r_result   <= w_result;
      r_mem_r_en <= mem_r_en;
      r_mem_w_en <= mem_w_en;
      r_wb_en    <= wb_en;
      r_dest     <= dest;
      r_st_val   <= st_val;
      r_status   <= (r_status & ~w_mask) | (w_nzcv & w_mask);
    end
  end

  assign out_valid    = r_valid;
  assign alu_result   = r_result;
  assign out_mem_r_en = r_mem_r_en;
  assign out_mem_w_en = r_mem_w_en;
  assign out_wb_en    = r_wb_en;
  assign out_dest     = r_dest;
  assign out_st_val   = r_st_val;
  assign status       = r_status;

endmodule
